// File: rtl/game_countdown_timer_pkg.sv
// game_countdown_timer_pkg
//   Shared types and constants for the round countdown timer.
//   - timer_state_t : round FSM states
//   - CNT_W / BCD_W : binary count width (0..99) and BCD digit width
//   - sat_count     : clamps a widened count to a ceiling
package game_countdown_timer_pkg;

    localparam int CNT_W = 7;
    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    // v carries one extra bit so count + bonus (max 114) never wraps.
    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W:0] v,
                                                   input logic [CNT_W:0] ceil);
        return (v > ceil) ? ceil[CNT_W-1:0] : v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/game_countdown_timer_if.sv
// game_countdown_timer_if
//   Control strobes into the timer and display/status outputs out of it.
//   master : game logic / display side (drives strobes, reads status)
//   slave  : the timer itself
interface game_countdown_timer_if;
    import game_countdown_timer_pkg::*;

    logic             tick_1s;
    logic             start;
    logic             pause;
    logic             bonus_add;
    logic [3:0]       bonus_sec;
    logic [BCD_W-1:0] secs_tens;
    logic [BCD_W-1:0] secs_ones;
    logic             running;
    logic             paused;
    logic             warning;
    logic             time_up;

    modport master (
        output tick_1s, start, pause, bonus_add, bonus_sec,
        input  secs_tens, secs_ones, running, paused, warning, time_up
    );

    modport slave (
        input  tick_1s, start, pause, bonus_add, bonus_sec,
        output secs_tens, secs_ones, running, paused, warning, time_up
    );

endinterface

// File: rtl/game_countdown_timer_bin2bcd_99.sv
// bin2bcd_99
//   Combinational 7-bit binary (0..99) to two-digit BCD converter.
//   bin  : binary value, 0..99
//   tens : BCD tens digit
//   ones : BCD ones digit
module bin2bcd_99
    import game_countdown_timer_pkg::*;
(
    input  logic [CNT_W-1:0] bin,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones
);

    // Comparator ladder: the last threshold crossed gives the tens digit.
    // The ones digit only needs the low nibble, since the remainder is < 10
    // and mod-16 subtraction of the low bits is exact.
    always_comb begin
        tens = '0;
        ones = bin[BCD_W-1:0];
        for (int i = 1; i <= 9; i++) begin
            if (bin >= CNT_W'(10 * i)) begin
                tens = BCD_W'(i);
                ones = bin[BCD_W-1:0] - BCD_W'(10 * i);
            end
        end
    end

endmodule

// File: rtl/game_countdown_timer.sv
// game_countdown_timer
//   Round timer: counts remaining seconds down from INIT_SECONDS on each
//   tick_1s strobe, with start/restart, pause and saturating bonus time.
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   tif  : slave modport -- tick_1s, start, pause, bonus_add, bonus_sec in;
//          secs_tens/secs_ones (BCD), running, paused, warning, time_up out
module game_countdown_timer
    import game_countdown_timer_pkg::*;
#(
    parameter int INIT_SECONDS = 60,
    parameter int WARN_SECONDS = 10,
    parameter int MAX_SECONDS  = 99
) (
    input  logic                  clk,
    input  logic                  rstn,
    game_countdown_timer_if.slave tif
);

    localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT_SECONDS);
    localparam logic [CNT_W-1:0] WARN_C = CNT_W'(WARN_SECONDS);
    localparam logic [CNT_W:0]   MAX_C  = (CNT_W+1)'(MAX_SECONDS);

    timer_state_t     state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_cnt;
    logic [CNT_W:0]   sum;
    logic [3:0]       add;
    logic             tick_eff;
    logic             time_up_q;

    // Ticks only count while RUNNING; the count!=0 guard keeps the widened
    // subtraction from ever wrapping.
    always_comb begin
        tick_eff = (state == RUNNING) && tif.tick_1s && (count != '0);
        add      = tif.bonus_add ? tif.bonus_sec : 4'd0;
        sum      = {1'b0, count} + {4'b0, add} - {{CNT_W{1'b0}}, tick_eff};
        next_cnt = sat_count(sum, MAX_C);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            count     <= INIT_C;
            time_up_q <= 1'b0;
        end else begin
            time_up_q <= 1'b0;
            if (tif.start) begin
                // Restart wins over any same-cycle tick, bonus or pause.
                state <= RUNNING;
                count <= INIT_C;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    RUNNING: begin
                        count <= next_cnt;
                        // Tick/bonus resolve first, so expiry beats pause.
                        if (next_cnt == '0) begin
                            state     <= EXPIRED;
                            time_up_q <= 1'b1;
                        end else if (tif.pause) begin
                            state <= PAUSED;
                        end
                    end
                    PAUSED: begin
                        // tick_eff is 0 here, so count only grows.
                        count <= next_cnt;
                        if (!tif.pause) state <= RUNNING;
                    end
                    EXPIRED: count <= '0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    bin2bcd_99 u_bcd (
        .bin  (count),
        .tens (tif.secs_tens),
        .ones (tif.secs_ones)
    );

    assign tif.running = (state == RUNNING);
    assign tif.paused  = (state == PAUSED);
    assign tif.warning = ((state == RUNNING) || (state == PAUSED)) &&
                         (count != '0) && (count <= WARN_C);
    assign tif.time_up = time_up_q;

endmodule
